ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder_if.sv | 13 +
 rtl/ram_responder.sv | 113 +++++++++++
 tb/tb_ram_responder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// Request/acknowledge bus between one requester (fetch or data) and the RAM responder.
interface ram_responder_if;
  logic        req;
  logic        wren;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic        ack;
  logic [31:0] r_data;
  logic        err;

  modport master (output req, wren, addr, w_data, input  ack, r_data, err);
  modport slave  (input  req, wren, addr, w_data, output ack, r_data, err);
endinterface

// File: rtl/ram_responder.sv
// Two-requester (A = fetch, B = data) responder over a single-port word RAM.
// Round-robin arbitration, one array access per cycle, single-cycle ack.
module ram_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LAT    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_responder_if.slave  a,
  ram_responder_if.slave  b
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANTED, ST_ACK} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  state_t              r_a_state, w_a_state_nxt;
  state_t              r_b_state, w_b_state_nxt;
  port_t               r_last, w_last_nxt;
  logic                w_a_elig, w_b_elig;
  logic                w_gnt_a, w_gnt_b, w_gnt;
  logic                w_sel_wren, w_sel_oor;
  logic [DATA_W-1:0]   w_sel_addr, w_sel_wdata;
  logic [ADDR_W-1:0]   w_sel_idx;
  logic [DATA_W-1:0]   w_rsp_data;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_a_ack, r_b_ack, r_a_err, r_b_err;
  logic [DATA_W-1:0]   r_a_rdata, r_b_rdata;

  // Single-cycle latency: the array access completes at the grant edge, so the
  // in-flight GRANTED step is folded into that edge and the FSM lands in ACK.
  function automatic state_t fsm_next(input state_t s, input logic gnt);
    state_t n;
    n = s;
    case (s)
      ST_IDLE:    if (gnt) n = (LAT == 32'd1) ? ST_ACK : ST_GRANTED;
      ST_GRANTED: n = ST_ACK;
      ST_ACK:     n = ST_IDLE;
      default:    n = ST_IDLE;
    endcase
    return n;
  endfunction

  // Eligibility, round-robin grant and next-state
  always_comb begin
    w_a_state_nxt = r_a_state;
    w_b_state_nxt = r_b_state;
    w_last_nxt    = r_last;
    w_gnt_a       = 1'b0;
    w_gnt_b       = 1'b0;
    w_a_elig      = a.req && (r_a_state == ST_IDLE);
    w_b_elig      = b.req && (r_b_state == ST_IDLE);

    if (w_a_elig && w_b_elig) begin
      if (r_last == PORT_A) w_gnt_b = 1'b1;
      else                  w_gnt_a = 1'b1;
    end else begin
      w_gnt_a = w_a_elig;
      w_gnt_b = w_b_elig;
    end

    if (w_gnt_a)      w_last_nxt = PORT_A;
    else if (w_gnt_b) w_last_nxt = PORT_B;

    w_a_state_nxt = fsm_next(r_a_state, w_gnt_a);
    w_b_state_nxt = fsm_next(r_b_state, w_gnt_b);
  end

  assign w_gnt       = w_gnt_a || w_gnt_b;
  assign w_sel_wren  = w_gnt_b ? b.wren   : a.wren;
  assign w_sel_addr  = w_gnt_b ? b.addr   : a.addr;
  assign w_sel_wdata = w_gnt_b ? b.w_data : a.w_data;
  assign w_sel_oor   = |w_sel_addr[DATA_W-1:ADDR_W];
  assign w_sel_idx   = w_sel_addr[ADDR_W-1:0];
  assign w_rsp_data  = (w_sel_wren || w_sel_oor) ? '0 : r_mem[w_sel_idx];

  // Array is never reset; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (w_gnt && w_sel_wren && !w_sel_oor) r_mem[w_sel_idx] <= w_sel_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_state <= ST_IDLE;
      r_b_state <= ST_IDLE;
      r_last    <= PORT_A;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_err   <= 1'b0;
      r_b_err   <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_a_state <= w_a_state_nxt;
      r_b_state <= w_b_state_nxt;
      r_last    <= w_last_nxt;
      r_a_ack   <= w_gnt_a;
      r_b_ack   <= w_gnt_b;
      r_a_err   <= w_gnt_a && w_sel_oor;
      r_b_err   <= w_gnt_b && w_sel_oor;
      r_a_rdata <= w_gnt_a ? w_rsp_data : '0;
      r_b_rdata <= w_gnt_b ? w_rsp_data : '0;
    end
  end

  assign a.ack    = r_a_ack;
  assign a.err    = r_a_err;
  assign a.r_data = r_a_rdata;
  assign b.ack    = r_b_ack;
  assign b.err    = r_b_err;
  assign b.r_data = r_b_rdata;
endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: per-port expected-response queues popped on ack.
module tb_ram_responder;
  localparam int unsigned ADDR_W = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [31:0] model [256];

  ram_responder_if a_if ();
  ram_responder_if b_if ();

  ram_responder #(.ADDR_W(ADDR_W), .LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_if),
    .b     (b_if)
  );

  always #5 clk = ~clk;

  // Response monitor: every ack consumes one expected entry; idle outputs must be zero
  always @(negedge clk) begin
    exp_t e;
    if (a_if.ack === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_ack: ack=1 with no outstanding request");
      end else begin
        e = q_a.pop_front();
        if ({a_if.r_data, a_if.err} !== {e.data, e.err}) begin
          errors++;
          $display("FAIL a_rsp: got data=%h err=%b, expected data=%h err=%b",
                   a_if.r_data, a_if.err, e.data, e.err);
        end
      end
    end else begin
      checks++;
      if (a_if.r_data !== 32'h0 || a_if.err !== 1'b0) begin
        errors++;
        $display("FAIL a_idle_zero: ack=%b data=%h err=%b, expected data=0 err=0",
                 a_if.ack, a_if.r_data, a_if.err);
      end
    end
    if (b_if.ack === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_ack: ack=1 with no outstanding request");
      end else begin
        e = q_b.pop_front();
        if ({b_if.r_data, b_if.err} !== {e.data, e.err}) begin
          errors++;
          $display("FAIL b_rsp: got data=%h err=%b, expected data=%h err=%b",
                   b_if.r_data, b_if.err, e.data, e.err);
        end
      end
    end else begin
      checks++;
      if (b_if.r_data !== 32'h0 || b_if.err !== 1'b0) begin
        errors++;
        $display("FAIL b_idle_zero: ack=%b data=%h err=%b, expected data=0 err=0",
                 b_if.ack, b_if.r_data, b_if.err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t predict(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    logic oor;
    oor    = (addr[31:ADDR_W] != '0);
    e.err  = oor;
    e.data = (wr || oor) ? 32'h0 : model[addr[ADDR_W-1:0]];
    if (wr && !oor) model[addr[ADDR_W-1:0]] = wd;
    return e;
  endfunction

  // Drives one transaction on a port, returns cycles from request to ack (bounded)
  task automatic txn(input bit pb, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, output int lat);
    bit got;
    if (pb) begin
      q_b.push_back(predict(wr, addr, wd));
      b_if.wren = wr; b_if.addr = addr; b_if.w_data = wd; b_if.req = 1'b1;
    end else begin
      q_a.push_back(predict(wr, addr, wd));
      a_if.wren = wr; a_if.addr = addr; a_if.w_data = wd; a_if.req = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      step();
      lat++;
      got = pb ? (b_if.ack === 1'b1) : (a_if.ack === 1'b1);
    end
    if (pb) b_if.req = 1'b0;
    else    a_if.req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    a_if.req = 0; a_if.wren = 0; a_if.addr = 0; a_if.w_data = 0;
    b_if.req = 0; b_if.wren = 0; b_if.addr = 0; b_if.w_data = 0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_if.ack, a_if.err, a_if.r_data} !== 34'h0) begin
      errors++;
      $display("FAIL reset_a_outputs: ack=%b err=%b data=%h, expected all zero",
               a_if.ack, a_if.err, a_if.r_data);
    end
    checks++;
    if ({b_if.ack, b_if.err, b_if.r_data} !== 34'h0) begin
      errors++;
      $display("FAIL reset_b_outputs: ack=%b err=%b data=%h, expected all zero",
               b_if.ack, b_if.err, b_if.r_data);
    end
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int lat;
    txn(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL b_write_latency: got %0d cycles, expected 1", lat); end
    txn(1'b0, 1'b0, 32'h10, 32'h0, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL a_read_latency: got %0d cycles, expected 1", lat); end
  endtask

  task automatic test_out_of_range();
    int lat;
    txn(1'b0, 1'b1, 32'h00, 32'h12345678, lat);
    txn(1'b0, 1'b0, 32'h100, 32'h0, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL oor_read_latency: got %0d cycles, expected 1", lat); end
    txn(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, lat);
    txn(1'b1, 1'b1, 32'h8000_0010, 32'h0BAD0BAD, lat);
    txn(1'b0, 1'b0, 32'h00, 32'h0, lat);
    txn(1'b1, 1'b0, 32'h10, 32'h0, lat);
  endtask

  task automatic test_arbitration();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    // Both request on the first cycle out of reset: B first, then A
    q_a.push_back(predict(1'b0, 32'h10, 32'h0));
    q_b.push_back(predict(1'b0, 32'h00, 32'h0));
    a_if.wren = 0; a_if.addr = 32'h10; a_if.req = 1'b1;
    b_if.wren = 0; b_if.addr = 32'h00; b_if.req = 1'b1;
    step();
    checks++;
    if ({a_if.ack, b_if.ack} !== 2'b01) begin
      errors++; $display("FAIL arb_first_grant: {a_ack,b_ack}=%b, expected 01", {a_if.ack, b_if.ack});
    end
    b_if.req = 1'b0;
    step();
    checks++;
    if ({a_if.ack, b_if.ack} !== 2'b10) begin
      errors++; $display("FAIL arb_second_grant: {a_ack,b_ack}=%b, expected 10", {a_if.ack, b_if.ack});
    end
    a_if.req = 1'b0;
    step();
    // Continuous requests: one ack per cycle, alternating, B first since A went last
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(predict(1'b0, 32'h10, 32'h0));
      q_b.push_back(predict(1'b0, 32'h00, 32'h0));
    end
    a_if.req = 1'b1;
    b_if.req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic [1:0] want;
      step();
      want = (k % 2 == 1) ? 2'b01 : 2'b10;
      checks++;
      if ({a_if.ack, b_if.ack} !== want) begin
        errors++;
        $display("FAIL arb_alternate_c%0d: {a_ack,b_ack}=%b, expected %b", k, {a_if.ack, b_if.ack}, want);
      end
      if (k == 8) begin a_if.req = 1'b0; b_if.req = 1'b0; end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    txn(1'b1, 1'b0, 32'h00, 32'h0, lat);
    q_a.push_back(predict(1'b1, 32'h20, 32'hCAFEF00D));
    q_b.push_back(predict(1'b0, 32'h20, 32'h0));
    a_if.wren = 1; a_if.addr = 32'h20; a_if.w_data = 32'hCAFEF00D; a_if.req = 1'b1;
    b_if.wren = 0; b_if.addr = 32'h20; b_if.req = 1'b1;
    step();
    checks++;
    if ({a_if.ack, b_if.ack} !== 2'b10) begin
      errors++; $display("FAIL b2b_write_first: {a_ack,b_ack}=%b, expected 10", {a_if.ack, b_if.ack});
    end
    a_if.req = 1'b0;
    step();
    checks++;
    if ({a_if.ack, b_if.ack} !== 2'b01) begin
      errors++; $display("FAIL b2b_read_second: {a_ack,b_ack}=%b, expected 01", {a_if.ack, b_if.ack});
    end
    b_if.req = 1'b0;
    step();
  endtask

  task automatic test_single_port_held();
    for (int i = 0; i < 3; i++) q_a.push_back(predict(1'b0, 32'h20, 32'h0));
    a_if.wren = 0; a_if.addr = 32'h20; a_if.req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      logic want;
      step();
      want = (k <= 5) && (k % 2 == 1);
      checks++;
      if (a_if.ack !== want) begin
        errors++; $display("FAIL held_req_c%0d: a_ack=%b, expected %b", k, a_if.ack, want);
      end
      if (k == 6) a_if.req = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    txn(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, lat);
    a_if.wren = 0; a_if.addr = 32'h30; a_if.req = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (a_if.ack !== 1'b1 || a_if.r_data !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL abort_pre_ack: ack=%b data=%h, expected ack=1 data=a5a5a5a5", a_if.ack, a_if.r_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_if.ack, a_if.err, a_if.r_data} !== 34'h0) begin
      errors++; $display("FAIL abort_immediate: ack=%b err=%b data=%h, expected all zero",
                         a_if.ack, a_if.err, a_if.r_data);
    end
    a_if.req = 1'b0;
    step();
    // Request pending across a reset edge is not granted
    b_if.wren = 0; b_if.addr = 32'h30; b_if.req = 1'b1;
    step();
    b_if.req = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({a_if.ack, b_if.ack} !== 2'b00) begin
        errors++; $display("FAIL abort_no_ack_c%0d: {a_ack,b_ack}=%b, expected 00", k, {a_if.ack, b_if.ack});
      end
    end
    txn(1'b1, 1'b0, 32'h30, 32'h0, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL abort_recover_latency: got %0d cycles, expected 1", lat); end
    txn(1'b0, 1'b0, 32'h10, 32'h0, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_arbitration();
    test_back_to_back();
    test_single_port_held();
    test_reset_abort();
    step();
    checks++;
    if (q_a.size() + q_b.size() != 0) begin
      errors++; $display("FAIL leftover_expected: a=%0d b=%0d outstanding, expected 0", q_a.size(), q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
